voice_mixer_pwm: RTL and testbench



---
 rtl/keyboard_pkg.sv | 15 +
 rtl/voice_envelope.sv | 83 ++++++++
 rtl/voice_mixer_pwm.sv | 101 ++++++++++
 tb/tb_voice_mixer_pwm.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keyboard_pkg.sv
// Shared types and constants for the keyboard audio back end.
//   env_state_t         - envelope FSM state encoding
//   ENV_MAX             - full-scale envelope level
//   ENV_STEP_CYCLES_DEF - default clk cycles per envelope step
//   PWM_W_DEF           - default PWM counter / duty width
package keyboard_pkg;

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

    localparam logic [3:0] ENV_MAX = 4'd15;

    localparam int unsigned ENV_STEP_CYCLES_DEF = 40000;
    localparam int unsigned PWM_W_DEF           = 8;

endpackage

// File: rtl/voice_envelope.sv
// Per-voice envelope shaper.
// Macro VOICE_ENVELOPE_EN selects the attack/sustain/release FSM; without it the
// level is simply gate ? 15 : 0, registered.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high
//   gate  in  key-held flag (level-sensitive)
//   tick  in  envelope step strobe from the shared prescaler
//   level out 4-bit envelope level
module voice_envelope
    import keyboard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       gate,
    input  logic       tick,
    output logic [3:0] level
);

`ifdef VOICE_ENVELOPE_EN
    env_state_t state_q, state_d;
    logic [3:0] level_q, level_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= 4'd0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    // A gate-driven transition takes priority over a tick in the same cycle,
    // so the level only steps when the gate agrees with the current phase.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            IDLE: begin
                if (gate) state_d = ATTACK;
            end
            ATTACK: begin
                if (!gate) begin
                    state_d = RELEASE;
                end else if (tick) begin
                    if (level_q != ENV_MAX) level_d = level_q + 4'd1;
                    if (level_q >= ENV_MAX - 4'd1) state_d = SUSTAIN;
                end
            end
            SUSTAIN: begin
                level_d = ENV_MAX;
                if (!gate) state_d = RELEASE;
            end
            RELEASE: begin
                if (gate) begin
                    state_d = ATTACK;
                end else if (tick) begin
                    if (level_q != 4'd0) level_d = level_q - 4'd1;
                    if (level_q <= 4'd1) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign level = level_q;
`else
    logic [3:0] level_q;
    logic       unused_tick;

    always_ff @(posedge clk) begin
        if (reset) level_q <= 4'd0;
        else       level_q <= gate ? ENV_MAX : 4'd0;
    end

    assign unused_tick = tick;
    assign level       = level_q;
`endif

endmodule

// File: rtl/voice_mixer_pwm.sv
// Voice mixer and PWM audio output.
// Scales each voice sample by its envelope level, sums the voices and drives a
// single-bit PWM stream whose duty is refreshed once per PWM frame.
// Macro VOICE_ENVELOPE_EN enables the envelope FSMs and their step prescaler.
// Ports:
//   clk         in  system clock
//   reset       in  synchronous, active-high
//   sample      in  NVOICE unsigned samples, voice 0 in the LSBs
//   gate        in  per-voice key-held flags
//   pwm_out     out PWM audio bit
//   mix_out     out duty value in force for the current frame
//   frame_start out one-cycle pulse in the first cycle of each frame
module voice_mixer_pwm
    import keyboard_pkg::*;
#(
    parameter int unsigned NVOICE          = 3,
    parameter int unsigned SAMPLE_W        = 4,
    parameter int unsigned ENV_STEP_CYCLES = ENV_STEP_CYCLES_DEF,
    parameter int unsigned PWM_W           = PWM_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NVOICE*SAMPLE_W-1:0]   sample,
    input  logic [NVOICE-1:0]            gate,
    output logic                         pwm_out,
    output logic [PWM_W-1:0]             mix_out,
    output logic                         frame_start
);

    localparam int unsigned PROD_W = SAMPLE_W + 4;
    localparam int unsigned SUM_W  = PROD_W + $clog2(NVOICE);

    logic              tick;
    logic [3:0]        level [NVOICE];
    logic [PROD_W-1:0] prod  [NVOICE];
    logic [SUM_W-1:0]  sum;
    logic [1:0]        unused_sum_lsb;

`ifdef VOICE_ENVELOPE_EN
    localparam int unsigned PRE_W = $clog2(ENV_STEP_CYCLES);

    logic [PRE_W-1:0] presc_q;

    assign tick = (presc_q == PRE_W'(ENV_STEP_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)     presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + 1'b1;
    end
`else
    assign tick = 1'b0;
`endif

    for (genvar v = 0; v < NVOICE; v++) begin : g_voice
        voice_envelope u_env (
            .clk   (clk),
            .reset (reset),
            .gate  (gate[v]),
            .tick  (tick),
            .level (level[v])
        );

        assign prod[v] = PROD_W'(sample[v*SAMPLE_W +: SAMPLE_W]) * PROD_W'(level[v]);
    end

    always_comb begin
        sum = '0;
        for (int v = 0; v < NVOICE; v++) begin
            sum = sum + SUM_W'(prod[v]);
        end
    end

    // Dropping the two LSBs keeps the worst-case three-voice mix inside the duty range.
    assign unused_sum_lsb = sum[1:0];

    logic [PWM_W-1:0] cnt_q, duty_q;
    logic             pwm_q, frame_start_q;
    logic             wrap;

    assign wrap = (cnt_q == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            duty_q        <= '0;
            pwm_q         <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_q + 1'b1;
            pwm_q         <= (cnt_q < duty_q);
            frame_start_q <= wrap;
            if (wrap) duty_q <= PWM_W'(sum[SUM_W-1:2]);
        end
    end

    assign pwm_out     = pwm_q;
    assign mix_out     = duty_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
module tb_voice_mixer_pwm;

    localparam int STEP  = 4;
    localparam int FRAME = 256;
`ifdef VOICE_ENVELOPE_EN
    localparam bit ENV_EN = 1'b1;
`else
    localparam bit ENV_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] sample;
    logic [2:0]  gate;
    logic        pwm_out;
    logic [7:0]  mix_out;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    voice_mixer_pwm #(
        .NVOICE          (3),
        .SAMPLE_W        (4),
        .ENV_STEP_CYCLES (STEP),
        .PWM_W           (8)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .sample      (sample),
        .gate        (gate),
        .pwm_out     (pwm_out),
        .mix_out     (mix_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state of the back end after each clock edge.
    // Envelope states: 0 idle, 1 attack, 2 sustain, 3 release.
    int m_presc = 0, m_cnt = 0, m_duty = 0, m_fs = 0, m_pwm = 0;
    int m_st [3] = '{0, 0, 0};
    int m_lvl[3] = '{0, 0, 0};

    always @(posedge clk) begin
        int mix;
        int tk;
        int g;
        if (reset) begin
            m_presc = 0; m_cnt = 0; m_duty = 0; m_fs = 0; m_pwm = 0;
            for (int v = 0; v < 3; v++) begin
                m_st[v]  = 0;
                m_lvl[v] = 0;
            end
        end else begin
            mix = 0;
            for (int v = 0; v < 3; v++) mix += int'(sample[v*4 +: 4]) * m_lvl[v];
            mix = mix / 4;
            tk  = (ENV_EN && m_presc == STEP - 1) ? 1 : 0;

            m_pwm = (m_cnt < m_duty) ? 1 : 0;
            m_fs  = (m_cnt == FRAME - 1) ? 1 : 0;
            if (m_cnt == FRAME - 1) m_duty = mix;
            m_cnt   = (m_cnt + 1) % FRAME;
            m_presc = (m_presc + 1) % STEP;

            for (int v = 0; v < 3; v++) begin
                g = int'(gate[v]);
                if (!ENV_EN) begin
                    m_lvl[v] = g ? 15 : 0;
                end else begin
                    case (m_st[v])
                        0: if (g) m_st[v] = 1;
                        1: if (!g) m_st[v] = 3;
                           else if (tk) begin
                               m_lvl[v] = (m_lvl[v] < 15) ? m_lvl[v] + 1 : 15;
                               if (m_lvl[v] == 15) m_st[v] = 2;
                           end
                        2: if (!g) m_st[v] = 3;
                        default: if (g) m_st[v] = 1;
                           else if (tk) begin
                               m_lvl[v] = (m_lvl[v] > 0) ? m_lvl[v] - 1 : 0;
                               if (m_lvl[v] == 0) m_st[v] = 0;
                           end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pwm_out", int'(pwm_out), m_pwm);
            check("mix_out", int'(mix_out), m_duty);
            check("frame_start", int'(frame_start), m_fs);
            check("level0", int'(u_dut.level[0]), m_lvl[0]);
            check("level1", int'(u_dut.level[1]), m_lvl[1]);
            check("level2", int'(u_dut.level[2]), m_lvl[2]);
        end
    end

    // Wait for the next frame start, then count high cycles across that frame.
    task automatic measure_frame(input string name, input int exp_mix);
        int n;
        int highs;
        n = 0;
        while (!frame_start && n < FRAME + 40) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            check({name, "_fs_timeout"}, 0, 1);
        end else begin
            check({name, "_mix"}, int'(mix_out), exp_mix);
            highs = 0;
            repeat (FRAME) begin
                @(negedge clk);
                highs += int'(pwm_out);
            end
            check({name, "_highs"}, highs, exp_mix);
        end
    endtask

    task automatic wait_level(input int v, input int lvl, input int budget, input string name);
        int n;
        n = 0;
        while (int'(u_dut.level[v]) != lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (int'(u_dut.level[v]) != lvl) check({name, "_timeout"}, int'(u_dut.level[v]), lvl);
    endtask

    task automatic wait_tick_next(input string name);
        int n;
        n = 0;
        while (m_presc != STEP - 1 && n < 2 * STEP) begin
            @(negedge clk);
            n++;
        end
        if (m_presc != STEP - 1) check({name, "_tick_timeout"}, m_presc, STEP - 1);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        gate   = 3'b111;
        sample = 12'hFFF;
        @(posedge clk);
        cmp_en = 1'b1;

        // Reset held with everything active: outputs stay low.
        repeat (3) begin
            @(negedge clk);
            check("rst_pwm", int'(pwm_out), 0);
            check("rst_mix", int'(mix_out), 0);
            check("rst_fs", int'(frame_start), 0);
        end

        // Release: first frame start lands 256 cycles later with a zero mix.
        reset = 1'b0;
        gate  = 3'b000;
        n = 0;
        while (!frame_start && n < FRAME + 20) begin
            @(negedge clk);
            n++;
            if (!frame_start) check("pre_frame_mix", int'(mix_out), 0);
        end
        check("first_fs_cycle", n, FRAME);
        check("first_frame_mix", int'(mix_out), 0);

        // Attack to full level on voice 0, then one full frame at 225>>2.
        gate   = 3'b001;
        sample = 12'h00F;
        n = 0;
        while (int'(u_dut.level[0]) != 15 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ENV_EN) check("attack_within_61", (n <= 61) ? 1 : 0, 1);
        else        check("gate_level_latency", n, 1);
        measure_frame("attack", 56);

`ifdef VOICE_ENVELOPE_EN
        // Release, then retrigger at level 9 on a tick cycle: level holds at 9.
        gate = 3'b000;
        wait_level(0, 9, 100, "release_to_9");
        wait_tick_next("retrig");
        gate = 3'b001;
        @(negedge clk);
        check("retrig_level_hold", int'(u_dut.level[0]), 9);
        check("retrig_state_attack", m_st[0], 1);
        wait_level(0, 10, 2 * STEP, "retrig_rise");
        check("retrig_resume", int'(u_dut.level[0]), 10);

        // Gate drop on a tick cycle while attacking: level holds at 12.
        wait_level(0, 12, 4 * STEP, "attack_to_12");
        wait_tick_next("drop");
        gate = 3'b000;
        @(negedge clk);
        check("drop_level_hold", int'(u_dut.level[0]), 12);
        wait_level(0, 11, 2 * STEP, "drop_fall");
        check("drop_decay", int'(u_dut.level[0]), 11);
`endif

        // Full mix: all voices at 15 with full-scale samples.
        gate   = 3'b111;
        sample = 12'hFFF;
        repeat (80) @(negedge clk);
        measure_frame("full", 168);

        // Voice 1 alone with sample 8.
        gate = 3'b000;
        repeat (2) @(negedge clk);
        gate   = 3'b010;
        sample = 12'h080;
        @(negedge clk);
`ifndef VOICE_ENVELOPE_EN
        check("gate1_level", int'(u_dut.level[1]), 15);
`endif
        repeat (80) @(negedge clk);
        measure_frame("voice1", 30);

        // Random traffic with occasional mid-frame resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 15) == 0) gate = 3'($urandom);
            if ($urandom_range(0, 7) == 0) sample = 12'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
